// File: rtl/mem_byte_dp_pkg.sv
// mem_pkg: shared types and lane-enable helper for mem_byte_dp.
// Access sizes are log2 of the byte count (byte, half, word, dword).
package mem_pkg;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} mem_size_e;

    typedef enum logic {ST_CLEAR, ST_RUN} mem_state_e;

    // Byte-lane enables for 2^size bytes starting at lane offset.
    // Sized for the widest port (8 lanes); callers truncate to BYTES.
    function automatic logic [7:0] lane_mask(input logic [1:0] size,
                                             input logic [2:0] offset);
        logic [15:0] m;
        m = ((16'd1 << (5'd1 << size)) - 16'd1) << offset;
        return m[7:0];
    endfunction

endpackage

// File: rtl/mem_byte_dp_if.sv
// mem_byte_dp_if: fetch port, data port and ready flag of mem_byte_dp.
// master = core side, slave = memory side.
interface mem_byte_dp_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 32
);
    logic             ready;
    logic             if_req;
    logic [AW-1:0]    if_addr;
    logic [WIDTH-1:0] if_rdata;
    logic             if_valid;
    logic             if_err;
    logic             d_req;
    logic             d_we;
    logic [1:0]       d_size;
    logic [AW-1:0]    d_addr;
    logic [WIDTH-1:0] d_wdata;
    logic [WIDTH-1:0] d_rdata;
    logic             d_valid;
    logic             d_err;

    modport master (
        input  ready, if_rdata, if_valid, if_err,
        input  d_rdata, d_valid, d_err,
        output if_req, if_addr,
        output d_req, d_we, d_size, d_addr, d_wdata
    );

    modport slave (
        output ready, if_rdata, if_valid, if_err,
        output d_rdata, d_valid, d_err,
        input  if_req, if_addr,
        input  d_req, d_we, d_size, d_addr, d_wdata
    );

endinterface

// File: rtl/mem_byte_dp_clear_ctrl.sv
// mem_clear_ctrl: post-reset sequencer that zeroes one word per cycle
// and raises ready once the last word has been written.
module mem_clear_ctrl
    import mem_pkg::*;
#(
    parameter int WORDS = 64,
    localparam int IW   = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          ready,
    output logic          clr_we,
    output logic [IW-1:0] clr_idx
);
    localparam logic [0:0] S_CLEAR = 1'(ST_CLEAR);
    localparam logic [0:0] S_RUN   = 1'(ST_RUN);

    logic [0:0]    state;
    logic [IW-1:0] idx;

    // Walk the index through every word, then park in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_CLEAR;
            idx   <= '0;
        end else if (state == S_CLEAR) begin
            if (idx == IW'(WORDS - 1)) begin
                state <= S_RUN;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign ready   = (state == S_RUN);
    assign clr_we  = (state == S_CLEAR);
    assign clr_idx = idx;

endmodule

// File: rtl/mem_byte_dp.sv
// mem_byte_dp: dual-port byte-addressable little-endian memory with
// registered reads. Optional macro: MEM_MISALIGN_TRAP_EN.
module mem_byte_dp
    import mem_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 256,
    parameter int AW        = 32,
    parameter     INIT_FILE = "ins.dat"
) (
    input logic          clk,
    input logic          rst,
    mem_byte_dp_if.slave bus
);
    localparam int BYTES = WIDTH / 8;
    localparam int LB    = $clog2(BYTES);
    localparam int WORDS = DEPTH / BYTES;
    localparam int IW    = $clog2(WORDS);
    localparam logic [1:0] MAXSZ = 2'(LB);

    // The clear sequence overwrites every word before the first access,
    // so a preloaded image can never be observed through the ports.
    if (INIT_FILE == "") begin : g_no_image
    end

    logic [WIDTH-1:0] mem [WORDS];

    logic          ready;
    logic          clr_we;
    logic [IW-1:0] clr_idx;

    mem_clear_ctrl #(.WORDS(WORDS)) u_clr (
        .clk     (clk),
        .rst     (rst),
        .ready   (ready),
        .clr_we  (clr_we),
        .clr_idx (clr_idx)
    );

    assign bus.ready = ready;

    logic [AW:0]       d_end;
    logic [AW:0]       f_end;
    logic [2:0]        amask;
    logic [LB-1:0]     d_off;
    logic              d_bad;
    logic              f_bad;
    logic [IW-1:0]     d_idx;
    logic [IW-1:0]     f_idx;
    logic [BYTES-1:0]  wmask;
    logic [BYTES-1:0]  keep;
    logic [WIDTH-1:0]  wsh;
    logic [WIDTH-1:0]  rsh;
    logic [WIDTH-1:0]  ldata;
    logic              d_go;
    logic              f_go;
    logic              st_ok;

    // Address decode, error detection and byte-lane steering.
    always_comb begin
        amask = (3'd1 << bus.d_size) - 3'd1;
        d_end = {1'b0, bus.d_addr} + ((AW + 1)'(1) << bus.d_size);
        f_end = {1'b0, bus.if_addr} + (AW + 1)'(BYTES);
        d_off = bus.d_addr[LB-1:0] & ~amask[LB-1:0];
        d_idx = bus.d_addr[LB +: IW];
        f_idx = bus.if_addr[LB +: IW];
        d_bad = (bus.d_size > MAXSZ) || (d_end > (AW + 1)'(DEPTH));
        f_bad = (f_end > (AW + 1)'(DEPTH));
`ifdef MEM_MISALIGN_TRAP_EN
        d_bad = d_bad || (|(bus.d_addr[LB-1:0] & amask[LB-1:0]));
        f_bad = f_bad || (|bus.if_addr[LB-1:0]);
`endif
        wmask = BYTES'(lane_mask(bus.d_size, 3'(d_off)));
        keep  = BYTES'(lane_mask(bus.d_size, 3'd0));
        wsh   = bus.d_wdata << {d_off, 3'b000};
        rsh   = mem[d_idx] >> {d_off, 3'b000};
        ldata = '0;
        for (int b = 0; b < BYTES; b++) begin
            if (keep[b]) ldata[8*b +: 8] = rsh[8*b +: 8];
        end
        d_go  = bus.d_req & ready;
        f_go  = bus.if_req & ready;
        st_ok = d_go & bus.d_we & ~d_bad;
    end

    // Storage: clear writes whole words, stores write enabled lanes.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_idx] <= '0;
        end else if (st_ok) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wmask[b]) mem[d_idx][8*b +: 8] <= wsh[8*b +: 8];
            end
        end
    end

    // Response registers; fetch sees pre-store data on a same-word hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.if_valid <= 1'b0;
            bus.if_err   <= 1'b0;
            bus.if_rdata <= '0;
            bus.d_valid  <= 1'b0;
            bus.d_err    <= 1'b0;
            bus.d_rdata  <= '0;
        end else begin
            bus.if_valid <= f_go;
            bus.if_err   <= f_go & f_bad;
            bus.if_rdata <= (f_go & ~f_bad) ? mem[f_idx] : '0;
            bus.d_valid  <= d_go;
            bus.d_err    <= d_go & d_bad;
            bus.d_rdata  <= (d_go & ~bus.d_we & ~d_bad) ? ldata : '0;
        end
    end

endmodule

// File: tb/tb_mem_byte_dp.sv
// tb_mem_byte_dp: directed and random checks of mem_byte_dp against
// a byte-array reference model.
module tb_mem_byte_dp;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] ref_mem [256];

    always #5 clk = ~clk;

    mem_byte_dp_if #(.WIDTH(32), .AW(32)) bus ();

    mem_byte_dp #(
        .WIDTH(32), .DEPTH(256), .AW(32), .INIT_FILE("ins.dat")
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit d_error(input logic [31:0] a, input int sz);
        bit e;
        e = (sz > 2) || ((a + (32'd1 << sz)) > 32'd256);
`ifdef MEM_MISALIGN_TRAP_EN
        if (sz <= 2 && (a % (32'd1 << sz)) != 0) e = 1'b1;
`endif
        return e;
    endfunction

    function automatic bit f_error(input logic [31:0] a);
        bit e;
        e = (a + 32'd4) > 32'd256;
`ifdef MEM_MISALIGN_TRAP_EN
        if (a % 4 != 0) e = 1'b1;
`endif
        return e;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a,
                                           input int n);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[a + i];
        return v;
    endfunction

    task automatic idle_bus();
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_size  = 2'd0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
    endtask

    // One cycle of traffic on both ports, checked against the model.
    task automatic op(input string tag, input bit fq,
                      input logic [31:0] fa, input bit dq, input bit we,
                      input int sz, input logic [31:0] da,
                      input logic [31:0] wd);
        bit          fe, de;
        int          n;
        logic [31:0] base, exp_f, exp_d;
        fe    = f_error(fa);
        exp_f = (fq && !fe) ? ref_rd(fa & ~32'd3, 4) : 32'd0;
        de    = d_error(da, sz);
        n     = 1 << sz;
        base  = da - (da % n);
        exp_d = (dq && !we && !de) ? ref_rd(base, n) : 32'd0;
        if (dq && we && !de) begin
            for (int i = 0; i < n; i++) ref_mem[base + i] = wd[8*i +: 8];
        end
        bus.if_req  = fq;
        bus.if_addr = fa;
        bus.d_req   = dq;
        bus.d_we    = we;
        bus.d_size  = 2'(sz);
        bus.d_addr  = da;
        bus.d_wdata = wd;
        @(posedge clk);
        #1;
        idle_bus();
        chk({tag, ".if_valid"}, 64'(bus.if_valid), 64'(fq));
        chk({tag, ".if_err"}, 64'(bus.if_err), 64'(fq && fe));
        chk({tag, ".if_rdata"}, 64'(bus.if_rdata), 64'(exp_f));
        chk({tag, ".d_valid"}, 64'(bus.d_valid), 64'(dq));
        chk({tag, ".d_err"}, 64'(bus.d_err), 64'(dq && de));
        chk({tag, ".d_rdata"}, 64'(bus.d_rdata), 64'(exp_d));
    endtask

    task automatic wait_ready(input string tag, input bit poke);
        int n;
        n = 0;
        while (!bus.ready && n < 100) begin
            if (poke) begin
                bus.if_req  = 1'b1;
                bus.if_addr = 32'h40;
                bus.d_req   = 1'b1;
                bus.d_we    = 1'b1;
                bus.d_size  = 2'd2;
                bus.d_addr  = 32'h40;
                bus.d_wdata = 32'hFFFF_FFFF;
            end
            @(posedge clk);
            #1;
            n++;
            if (poke) chk({tag, ".busy_valid"},
                          64'({bus.if_valid, bus.d_valid}), 64'd0);
        end
        idle_bus();
        chk({tag, ".len"}, 64'(n), 64'd64);
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    endtask

    task automatic pulse_rst(input string tag);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk({tag, ".ready"}, 64'(bus.ready), 64'd0);
        chk({tag, ".valid"}, 64'({bus.if_valid, bus.d_valid}), 64'd0);
        chk({tag, ".err"}, 64'({bus.if_err, bus.d_err}), 64'd0);
        chk({tag, ".rdata"}, {bus.if_rdata, bus.d_rdata}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        bit          fq, dq, we;
        int          sz;
        logic [31:0] fa, da;

        idle_bus();
        @(posedge clk);
        #1;

        pulse_rst("rst0");
        wait_ready("clear0", 1'b1);
        for (int w = 0; w < 64; w++) begin
            op("zero", 1'b1, 32'(4 * w), 1'b0, 1'b0, 0, 0, 0);
        end

        op("pre_mid", 1'b0, 0, 1'b1, 1'b1, 2, 32'h80, 32'h1111_2222);
        pulse_rst("rst1");
        repeat (30) begin
            @(posedge clk);
            #1;
        end
        pulse_rst("rst_mid");
        wait_ready("clear_mid", 1'b0);
        op("mid_gone", 1'b0, 0, 1'b1, 1'b0, 2, 32'h80, 0);

        op("sw10", 1'b0, 0, 1'b1, 1'b1, 2, 32'h10, 32'hDEAD_BEEF);
        op("sb11", 1'b0, 0, 1'b1, 1'b1, 0, 32'h11, 32'h0000_0055);
        op("sh12", 1'b0, 0, 1'b1, 1'b1, 1, 32'h12, 32'h0000_A5A5);
        op("lw10", 1'b0, 0, 1'b1, 1'b0, 2, 32'h10, 0);
        chk("lw10.const", 64'(bus.d_rdata), 64'hA5A5_55EF);
        op("lb13", 1'b0, 0, 1'b1, 1'b0, 0, 32'h13, 0);
        chk("lb13.const", 64'(bus.d_rdata), 64'h0000_00A5);

        op("sw20", 1'b0, 0, 1'b1, 1'b1, 2, 32'h20, 32'h0BAD_F00D);
        op("conflict", 1'b1, 32'h20, 1'b1, 1'b1, 2, 32'h20, 32'h1234_5678);
        chk("conflict.old", 64'(bus.if_rdata), 64'h0BAD_F00D);
        op("fetch20", 1'b1, 32'h20, 1'b0, 1'b0, 0, 0, 0);
        chk("fetch20.new", 64'(bus.if_rdata), 64'h1234_5678);

        op("lw_fe", 1'b0, 0, 1'b1, 1'b0, 2, 32'hFE, 0);
        chk("lw_fe.err", 64'(bus.d_err), 64'd1);
        op("sd40", 1'b0, 0, 1'b1, 1'b1, 3, 32'h40, 32'h7777_7777);
        chk("sd40.err", 64'(bus.d_err), 64'd1);
        op("lw40", 1'b0, 0, 1'b1, 1'b0, 2, 32'h40, 0);
        chk("lw40.const", 64'(bus.d_rdata), 64'd0);

        op("sw30", 1'b0, 0, 1'b1, 1'b1, 2, 32'h30, 32'hCAFE_BABE);
        op("lh31", 1'b0, 0, 1'b1, 1'b0, 1, 32'h31, 0);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("lh31.err", 64'(bus.d_err), 64'd1);
        chk("lh31.rdata", 64'(bus.d_rdata), 64'd0);
`else
        chk("lh31.err", 64'(bus.d_err), 64'd0);
        chk("lh31.rdata", 64'(bus.d_rdata), 64'h0000_BABE);
`endif

        for (int i = 0; i < 400; i++) begin
            fq = ($urandom_range(0, 3) != 0);
            dq = ($urandom_range(0, 3) != 0);
            we = ($urandom_range(0, 1) == 1);
            sz = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
            fa = ($urandom_range(0, 9) == 0) ? $urandom_range(248, 259)
                                            : $urandom_range(0, 255);
            da = ($urandom_range(0, 9) == 0) ? $urandom_range(248, 259)
                                            : $urandom_range(0, 63);
            op("rand", fq, fa, dq, we, sz, da, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
